aes_cipher_iter: RTL and testbench

Iterative AES forward cipher (encryption) for AES-128/192/256. It computes one round per clock.
- Input side: takes a 128-bit plaintext block and the pre-expanded round-key schedule.
- Output side: produces the 128-bit ciphertext, using a valid/ready handshake on both sides.
- It is the encrypt-side counterpart to the team's iterative inverse cipher and shares the same key-schedule format, so the two can be looped back in system tests.

---
 rtl/aes_cipher_iter.sv | 170 +++++++++++++++++
 tb/tb_aes_cipher_iter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_cipher_iter.sv
// rtl/aes_cipher_iter.sv - iterative AES-128/192/256 forward cipher, one round per clock
module aes_cipher_iter #(
    parameter int Nk = 4,
    parameter int Nr = Nk + 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [127:0]             plainText,
    input  logic [0:128*(Nr+1)-1]    keys,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [127:0]             cipherText,
    output logic                     busy
);

    // A zero Nr override falls back to the FIPS round count for Nk.
    localparam logic [3:0] LAST_ROUND = 4'((Nr > 0) ? Nr : Nk + 6);

    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

    fsm_t         fsm_q;
    logic [3:0]   round_q;
    logic [127:0] state_q;
    logic [127:0] cipher_q;
    logic         out_valid_q;
    logic         busy_q;

    logic [127:0] round_key;
    logic [127:0] round_d;
    logic [127:0] final_d;
    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [7:0]   mc [16];

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Inverse as a^254 by square-and-multiply, then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] inv;
        p   = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p   = gf_mul(p, p);
            inv = gf_mul(inv, p);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    always_comb begin
        round_key = keys[0 +: 128];
        for (int r = 0; r <= Nr; r++) begin
            if (round_q == 4'(r)) round_key = keys[128*r +: 128];
        end
    end

    // Byte n of the state is s(n%4, n/4); byte 0 sits in the top bits.
    always_comb begin
        logic [7:0] a0, a1, a2, a3;
        round_d = '0;
        final_d = '0;
        for (int i = 0; i < 16; i++) begin
            sb[i] = sbox(state_q[127-8*i -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[r+4*c] = sb[r+4*((c+r)%4)];
            end
        end
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4*c];
            a1 = sr[4*c+1];
            a2 = sr[4*c+2];
            a3 = sr[4*c+3];
            mc[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            mc[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            mc[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            mc[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        for (int i = 0; i < 16; i++) begin
            round_d[127-8*i -: 8] = mc[i];
            final_d[127-8*i -: 8] = sr[i];
        end
        round_d = round_d ^ round_key;
        final_d = final_d ^ round_key;
    end

    always_comb begin
        in_ready = 1'b0;
        case (fsm_q)
            IDLE:    in_ready = 1'b1;
            DONE:    in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q       <= IDLE;
            round_q     <= 4'd0;
            state_q     <= '0;
            cipher_q    <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q     <= plainText ^ keys[0 +: 128];
                        round_q     <= 4'd1;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b1;
                        fsm_q       <= ROUND;
                    end
                end
                ROUND: begin
                    if (round_q == LAST_ROUND) begin
                        cipher_q    <= final_d;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        fsm_q       <= DONE;
                    end else begin
                        state_q <= round_d;
                        round_q <= round_q + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (in_valid) begin
                            state_q <= plainText ^ keys[0 +: 128];
                            round_q <= 4'd1;
                            busy_q  <= 1'b1;
                            fsm_q   <= ROUND;
                        end else begin
                            fsm_q <= IDLE;
                        end
                    end
                end
                default: begin
                    fsm_q   <= IDLE;
                    round_q <= 4'd0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid  = out_valid_q;
    assign cipherText = cipher_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_aes_cipher_iter.sv
// tb/tb_aes_cipher_iter.sv - self-checking bench for aes_cipher_iter at Nk = 4, 6, 8
module tb_aes_cipher_iter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic         in_valid_a  [3];
    logic         out_ready_a [3];
    logic         in_ready_a  [3];
    logic         out_valid_a [3];
    logic         busy_a      [3];
    logic [127:0] pt_a        [3];
    logic [127:0] ct_a        [3];
    logic [0:128*11-1] keys4;
    logic [0:128*13-1] keys6;
    logic [0:128*15-1] keys8;

    aes_cipher_iter #(.Nk(4)) u_nk4 (
        .clk(clk), .reset(reset), .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
        .plainText(pt_a[0]), .keys(keys4), .out_valid(out_valid_a[0]),
        .out_ready(out_ready_a[0]), .cipherText(ct_a[0]), .busy(busy_a[0]));

    aes_cipher_iter #(.Nk(6)) u_nk6 (
        .clk(clk), .reset(reset), .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
        .plainText(pt_a[1]), .keys(keys6), .out_valid(out_valid_a[1]),
        .out_ready(out_ready_a[1]), .cipherText(ct_a[1]), .busy(busy_a[1]));

    aes_cipher_iter #(.Nk(8)) u_nk8 (
        .clk(clk), .reset(reset), .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]),
        .plainText(pt_a[2]), .keys(keys8), .out_valid(out_valid_a[2]),
        .out_ready(out_ready_a[2]), .cipherText(ct_a[2]), .busy(busy_a[2]));

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0]  sbox_m [256];
    logic [31:0] w      [60];

    task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs == exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from a brute-force multiplicative inverse plus the bitwise affine rule.
    task automatic init_sbox();
        logic [7:0] a, inv, s, c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            a   = x[7:0];
            inv = 8'h00;
            if (a != 8'h00) begin
                for (int y = 1; y < 256; y++) begin
                    if (gmul(a, y[7:0]) == 8'h01) inv = y[7:0];
                end
            end
            for (int i = 0; i < 8; i++) begin
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            end
            sbox_m[x] = s;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
    endfunction

    task automatic expand(input logic [255:0] key, input int nk);
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nk+7); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
    endtask

    task automatic model(input logic [255:0] key, input int nk, input logic [127:0] pt,
                         output logic [127:0] ct);
        logic [7:0] s [4][4];
        logic [7:0] t [4][4];
        logic [7:0] coef [4];
        int nr;
        coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        nr = nk + 6;
        expand(key, nk);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                s[r][c] = pt[127-8*(r+4*c) -: 8] ^ w[c][31-8*r -: 8];
        for (int rnd = 1; rnd <= nr; rnd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = sbox_m[s[r][(c+r)%4]];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    if (rnd < nr) begin
                        s[r][c] = 8'h00;
                        for (int k = 0; k < 4; k++) s[r][c] = s[r][c] ^ gmul(coef[(k-r+4)%4], t[k][c]);
                    end else begin
                        s[r][c] = t[r][c];
                    end
                    s[r][c] = s[r][c] ^ w[4*rnd+c][31-8*r -: 8];
                end
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                ct[127-8*(r+4*c) -: 8] = s[r][c];
    endtask

    task automatic load_key(input int k, input logic [255:0] key);
        logic [127:0] rk;
        expand(key, 4 + 2*k);
        for (int r = 0; r <= 10 + 2*k; r++) begin
            rk = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            case (k)
                0:       keys4[128*r +: 128] = rk;
                1:       keys6[128*r +: 128] = rk;
                default: keys8[128*r +: 128] = rk;
            endcase
        end
    endtask

    // Returns at the negedge just after the accept edge.
    task automatic accept(input int k, input logic [127:0] pt);
        @(negedge clk);
        pt_a[k]       = pt;
        in_valid_a[k] = 1'b1;
        chk_bit("in_ready_before_accept", in_ready_a[k], 1'b1);
        @(negedge clk);
        in_valid_a[k] = 1'b0;
    endtask

    task automatic wait_out(input int k, input int n0, output int n, output int nb);
        n  = n0;
        nb = 0;
        while (!out_valid_a[k] && n < 40) begin
            if (busy_a[k]) nb++;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_block(input string tag, input int k, input logic [127:0] pt,
                             input logic [127:0] exp);
        int n, nb;
        out_ready_a[k] = 1'b1;
        accept(k, pt);
        wait_out(k, 0, n, nb);
        chk_int({tag, "_latency"}, n, 10 + 2*k);
        chk_int({tag, "_busy_cycles"}, nb, 10 + 2*k);
        chk128({tag, "_ct"}, ct_a[k], exp);
        @(negedge clk);
        chk_bit({tag, "_out_valid_drop"}, out_valid_a[k], 1'b0);
        chk_bit({tag, "_in_ready_idle"}, in_ready_a[k], 1'b1);
    endtask

    function automatic logic [255:0] rand256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [255:0] key;
        logic [127:0] p1, p2, e1, e2, ref_ct;
        int n, nb, gap, seen;

        for (int k = 0; k < 3; k++) begin
            in_valid_a[k]  = 1'b0;
            out_ready_a[k] = 1'b1;
            pt_a[k]        = '0;
        end
        keys4 = '0;
        keys6 = '0;
        keys8 = '0;
        reset = 1'b1;
        init_sbox();
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk_bit("reset_out_valid", out_valid_a[k], 1'b0);
            chk_bit("reset_busy", busy_a[k], 1'b0);
            chk128("reset_ct", ct_a[k], 128'h0);
        end
        reset = 1'b0;
        #1;
        chk_bit("in_ready_after_reset", in_ready_a[0], 1'b1);

        // Known-answer vectors
        key = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
        model(key, 4, 128'h00112233445566778899aabbccddeeff, ref_ct);
        chk128("model_kat_nk4", ref_ct, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        load_key(0, key);
        run_block("kat_nk4", 0, 128'h00112233445566778899aabbccddeeff,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        key = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        load_key(0, key);
        run_block("kat_fips", 0, 128'h3243f6a8885a308d313198a2e0370734,
                  128'h3925841d02dc09fbdc118597196a0b32);
        key = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
        load_key(1, key);
        run_block("kat_nk6", 1, 128'h00112233445566778899aabbccddeeff,
                  128'hdda97ca4864cdfe06eaf70a0ec0d7191);
        key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        load_key(2, key);
        run_block("kat_nk8", 2, 128'h00112233445566778899aabbccddeeff,
                  128'h8ea2b7ca516745bfeafc49904b496089);

        // Random keys and plaintexts against the model
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 3; j++) begin
                key = rand256();
                p1  = rand128();
                model(key, 4 + 2*k, p1, e1);
                load_key(k, key);
                run_block("random", k, p1, e1);
            end
        end

        // Backpressure on the output
        key = rand256();
        p1  = rand128();
        model(key, 4, p1, e1);
        load_key(0, key);
        out_ready_a[0] = 1'b0;
        accept(0, p1);
        wait_out(0, 0, n, nb);
        chk_int("bp_latency", n, 10);
        repeat (5) begin
            @(negedge clk);
            chk_bit("bp_out_valid_hold", out_valid_a[0], 1'b1);
            chk128("bp_ct_hold", ct_a[0], e1);
            chk_bit("bp_in_ready_low", in_ready_a[0], 1'b0);
        end
        out_ready_a[0] = 1'b1;
        #1;
        chk_bit("bp_in_ready_follows", in_ready_a[0], 1'b1);
        @(negedge clk);
        out_ready_a[0] = 1'b0;
        chk_bit("bp_out_valid_drop", out_valid_a[0], 1'b0);
        chk_bit("bp_in_ready_idle", in_ready_a[0], 1'b1);
        chk128("bp_ct_retained", ct_a[0], e1);
        out_ready_a[0] = 1'b1;

        // Back-to-back blocks with in_valid held high
        p1 = rand128();
        p2 = rand128();
        model(key, 4, p1, e1);
        model(key, 4, p2, e2);
        @(negedge clk);
        pt_a[0]       = p1;
        in_valid_a[0] = 1'b1;
        @(negedge clk);
        pt_a[0] = p2;
        wait_out(0, 0, n, nb);
        chk_int("b2b_first_latency", n, 10);
        chk128("b2b_first_ct", ct_a[0], e1);
        @(negedge clk);
        in_valid_a[0] = 1'b0;
        chk_bit("b2b_second_accepted", busy_a[0], 1'b1);
        gap = 1;
        while (!out_valid_a[0] && gap < 40) begin
            @(negedge clk);
            gap++;
        end
        chk_int("b2b_output_spacing", gap, 11);
        chk128("b2b_second_ct", ct_a[0], e2);
        @(negedge clk);

        // in_valid during ROUND is ignored
        p1 = rand128();
        p2 = rand128();
        model(key, 4, p1, e1);
        accept(0, p1);
        repeat (3) @(negedge clk);
        pt_a[0]       = p2;
        in_valid_a[0] = 1'b1;
        @(negedge clk);
        in_valid_a[0] = 1'b0;
        wait_out(0, 4, n, nb);
        chk_int("ignore_latency", n, 10);
        chk128("ignore_ct", ct_a[0], e1);
        @(negedge clk);

        // Reset at round 5 aborts the block
        key = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
        load_key(0, key);
        accept(0, 128'h3243f6a8885a308d313198a2e0370734);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        chk_bit("abort_busy_cleared", busy_a[0], 1'b0);
        chk_bit("abort_out_valid", out_valid_a[0], 1'b0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid_a[0]) seen++;
        end
        chk_int("abort_no_output", seen, 0);
        run_block("after_abort", 0, 128'h00112233445566778899aabbccddeeff,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
